// File: rtl/imem_arbiter_if.sv
// Signal bundle between the instruction-memory arbiter, the CPU fetch stage,
// the program loader and the single-port memory.
interface imem_arbiter_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
);
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic [DATA_W-1:0] fetch_rdata;
   logic              fetch_valid;
   logic              cpu_stall;
   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_done;
   logic              ld_gnt;
   logic [DATA_W-1:0] ld_rdata;
   logic              ld_rvalid;
   logic              ld_err;
   logic [ADDR_W:0]   wr_count;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wd;
   logic [DATA_W-1:0] mem_rd;

   // Arbiter side.
   modport slave (
      input  fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_done, mem_rd,
      output fetch_rdata, fetch_valid, cpu_stall, ld_gnt, ld_rdata, ld_rvalid, ld_err,
             wr_count, mem_a, mem_we, mem_wd
   );

   // CPU / loader / memory side.
   modport master (
      output fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_done, mem_rd,
      input  fetch_rdata, fetch_valid, cpu_stall, ld_gnt, ld_rdata, ld_rvalid, ld_err,
             wr_count, mem_a, mem_we, mem_wd
   );
endinterface

// File: rtl/imem_arbiter.sv
// Shares a single-port instruction memory between CPU fetch and a program loader.
// BOOT lets only the loader in; RUN favours fetch with a starvation-bounded loader grant.
module imem_arbiter #(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_DEPTH  = 1024,
   parameter int unsigned STARVE_MAX = 8
) (
   input logic          clk,
   input logic          rst,
   imem_arbiter_if.slave bus
);
   localparam int unsigned    CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W:0] DEPTH     = MEM_DEPTH[ADDR_W:0];
   localparam logic [CNT_W-1:0] STARVE_LIM = STARVE_MAX[CNT_W-1:0];

   typedef enum logic [0:0] {StBoot, StRun} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  starve_q;
   logic [DATA_W-1:0] fetch_rdata_q;
   logic              fetch_valid_q;
   logic [DATA_W-1:0] ld_rdata_q;
   logic              ld_rvalid_q;
   logic              ld_err_q;
   logic [ADDR_W:0]   wr_count_q;

   logic in_range;
   logic forced;
   logic fetch_serve;
   logic ld_serve;

   always_comb begin
      in_range    = {1'b0, bus.ld_addr} < DEPTH;
      forced      = (state_q == StRun) && bus.ld_req && (starve_q == STARVE_LIM);
      fetch_serve = (state_q == StRun) && bus.fetch_req && !forced;
      // In BOOT fetch_serve is always 0, so the loader gets every request.
      ld_serve    = bus.ld_req && !fetch_serve;
   end

   assign bus.ld_gnt      = ld_serve & ~rst;
   assign bus.cpu_stall   = (state_q == StBoot) | forced;
   assign bus.mem_a       = ld_serve ? bus.ld_addr : bus.fetch_addr;
   assign bus.mem_we      = ld_serve & bus.ld_we & in_range & ~rst;
   assign bus.mem_wd      = bus.ld_wdata;
   assign bus.fetch_rdata = fetch_rdata_q;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.ld_rdata    = ld_rdata_q;
   assign bus.ld_rvalid   = ld_rvalid_q;
   assign bus.ld_err      = ld_err_q;
   assign bus.wr_count    = wr_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StBoot;
         starve_q      <= '0;
         fetch_rdata_q <= '0;
         fetch_valid_q <= 1'b0;
         ld_rdata_q    <= '0;
         ld_rvalid_q   <= 1'b0;
         ld_err_q      <= 1'b0;
         wr_count_q    <= '0;
      end else begin
         if (state_q == StBoot && bus.ld_done) begin
            state_q <= StRun;
         end

         if (state_q == StRun && bus.ld_req && !ld_serve) begin
            starve_q <= starve_q + 1'b1;
         end else begin
            starve_q <= '0;
         end

         fetch_valid_q <= fetch_serve;
         if (fetch_serve) begin
            fetch_rdata_q <= bus.mem_rd;
         end

         ld_rvalid_q <= ld_serve && !bus.ld_we && in_range;
         if (ld_serve && !bus.ld_we && in_range) begin
            ld_rdata_q <= bus.mem_rd;
         end

         ld_err_q <= ld_serve && !in_range;

         if (ld_serve && bus.ld_we && in_range && wr_count_q != DEPTH) begin
            wr_count_q <= wr_count_q + 1'b1;
         end
      end
   end
endmodule
